// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// MC_PERF_CNT_EN adds the InstrRet retired-instruction count.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, Neg, Ovf, Carry;
  logic       MemReady;
  logic       MemReq, MemWrite, IRWrite, PCWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       Fault;
`ifdef MC_PERF_CNT_EN
  logic [31:0] InstrRet;
`endif

  modport master (
    input  op, funct3, funct7b5, Zero, Neg, Ovf, Carry, MemReady,
`ifdef MC_PERF_CNT_EN
    output InstrRet,
`endif
    output MemReq, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegWrite, ALUControl, Fault
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Neg, Ovf, Carry, MemReady,
`ifdef MC_PERF_CNT_EN
    input  InstrRet,
`endif
    input  MemReq, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegWrite, ALUControl, Fault
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory handshake timeout and sticky fault.
// Optional macro MC_PERF_CNT_EN adds a retired-instruction counter (InstrRet).
module multicycle_controller #(
  parameter bit EXT_BRANCH = 1'b1,
  parameter int TIMEOUT    = 15,
  parameter int WAIT_W     = 4
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_FAULT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_state, stalled, timed_out;
  logic              br_legal, br_taken;
  logic [2:0]        alu_dec;

  // Only the three memory states wait on MemReady; a ready in the limit cycle wins.
  always_comb begin
    mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    stalled   = mem_state && !bus.MemReady;
    timed_out = stalled && (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));
  end

  always_comb begin
    br_legal = 1'b0;
    br_taken = 1'b0;
    case (bus.funct3)
      3'b000: begin br_legal = 1'b1;       br_taken = bus.Zero;                end
      3'b001: begin br_legal = EXT_BRANCH; br_taken = !bus.Zero;               end
      3'b100: begin br_legal = EXT_BRANCH; br_taken = bus.Neg ^ bus.Ovf;       end
      3'b101: begin br_legal = EXT_BRANCH; br_taken = !(bus.Neg ^ bus.Ovf);    end
      3'b110: begin br_legal = EXT_BRANCH; br_taken = !bus.Carry;              end
      3'b111: begin br_legal = EXT_BRANCH; br_taken = bus.Carry;               end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.funct3)
      3'b000:  alu_dec = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= (stalled && !timed_out) ? wait_cnt + 1'b1 : '0;
      case (state)
        S_FETCH:    if (timed_out) state <= S_FAULT;
                    else if (bus.MemReady) state <= S_DECODE;
        S_DECODE:
          case (bus.op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECR;
            OP_I:         state <= S_EXECI;
            OP_BR:        state <= S_BRANCH;
            OP_JAL:       state <= S_JAL;
            OP_LUI:       state <= S_LUI;
            default:      state <= S_FAULT;
          endcase
        S_MEMADR:   state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (timed_out) state <= S_FAULT;
                    else if (bus.MemReady) state <= S_MEMWB;
        S_MEMWRITE: if (timed_out) state <= S_FAULT;
                    else if (bus.MemReady) state <= S_FETCH;
        S_MEMWB:    state <= S_FETCH;
        S_EXECR, S_EXECI, S_LUI, S_JAL: state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= br_legal ? S_FETCH : S_FAULT;
        default:    state <= S_FAULT;
      endcase
    end
  end

  always_comb begin
    bus.MemReq     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ImmSrc     = 3'b000;
    bus.RegWrite   = 1'b0;
    bus.ALUControl = 3'b000;
    bus.Fault      = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemReq    = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = bus.op[5] ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_dec;
      end
      S_EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_dec;
      end
      S_LUI: begin
        bus.ALUSrcA = 2'b11;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = 3'b100;
      end
      S_ALUWB: bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = 3'b001;
        bus.PCWrite    = br_legal && br_taken;
      end
      // PC takes the target held in ALUOut while the ALU forms PC+4 for the link.
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
      end
      S_FAULT: bus.Fault = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic retire;
  always_comb
    retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
             ((state == S_MEMWRITE) && bus.MemReady);

  always_ff @(posedge clk) begin
    if (reset)       bus.InstrRet <= '0;
    else if (retire) bus.InstrRet <= bus.InstrRet + 32'd1;
  end
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: sequencing, branches, ALU decode, timeout, fault and reset.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  multicycle_controller_if b0 ();
  multicycle_controller_if b1 ();

  multicycle_controller #(.EXT_BRANCH(1'b1), .TIMEOUT(15), .WAIT_W(4))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  multicycle_controller #(.EXT_BRANCH(1'b0), .TIMEOUT(15), .WAIT_W(4))
    u1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic setop(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    b0.op = o; b0.funct3 = f3; b0.funct7b5 = f7;
  endtask

  initial begin
    b0.op = 7'b0000011; b0.funct3 = 3'b010; b0.funct7b5 = 1'b0;
    b0.Zero = 1'b0; b0.Neg = 1'b0; b0.Ovf = 1'b0; b0.Carry = 1'b0;
    b0.MemReady = 1'b0;
    // u1 only ever sees a ready memory and a bne
    b1.op = 7'b1100011; b1.funct3 = 3'b001; b1.funct7b5 = 1'b0;
    b1.Zero = 1'b0; b1.Neg = 1'b0; b1.Ovf = 1'b0; b1.Carry = 1'b0;
    b1.MemReady = 1'b1;

    do_reset();
    #1;
    chk("rst_fault", b0.Fault, 0);
    chk("rst_memreq", b0.MemReq, 1);
    chk("rst_pcwrite", b0.PCWrite, 0);
    chk("rst_alusrcb", b0.ALUSrcB, 2);
    chk("rst_resultsrc", b0.ResultSrc, 2);
    chk("rst_u1_fault", b1.Fault, 0);
`ifdef MC_PERF_CNT_EN
    chk("rst_instrret", b0.InstrRet, 0);
`endif

    // FETCH wait three cycles; u1 walks FETCH->DECODE->BRANCH->FAULT meanwhile
    tick(); #1;
    chk("fw1_irwrite", b0.IRWrite, 0);
    tick(); #1;
    chk("fw2_pcwrite", b0.PCWrite, 0);
    chk("u1_br_pcwrite", b1.PCWrite, 0);
    chk("u1_br_fault", b1.Fault, 0);
    tick();
    b0.MemReady = 1'b1; #1;
    chk("fw4_irwrite", b0.IRWrite, 1);
    chk("fw4_pcwrite", b0.PCWrite, 1);
    chk("u1_fault", b1.Fault, 1);
    chk("u1_fault_memreq", b1.MemReq, 0);

    // lw: DECODE, MEMADR, MEMREAD, MEMWB, back to FETCH
    tick(); #1;
    chk("lw_dec_memreq", b0.MemReq, 0);
    chk("lw_dec_immsrc", b0.ImmSrc, 2);
    chk("lw_dec_srca", b0.ALUSrcA, 1);
    tick(); #1;
    chk("lw_adr_srca", b0.ALUSrcA, 2);
    chk("lw_adr_immsrc", b0.ImmSrc, 0);
    tick(); #1;
    chk("lw_rd_memreq", b0.MemReq, 1);
    chk("lw_rd_adrsrc", b0.AdrSrc, 1);
    chk("lw_rd_memwrite", b0.MemWrite, 0);
    tick(); #1;
    chk("lw_wb_regwrite", b0.RegWrite, 1);
    chk("lw_wb_resultsrc", b0.ResultSrc, 1);
    setop(7'b1100011, 3'b001, 1'b0);
    b0.Zero = 1'b0;
    tick(); #1;
    chk("lw_fetch_adrsrc", b0.AdrSrc, 0);
    chk("lw_fetch_memreq", b0.MemReq, 1);

    // bne Zero=0 -> taken
    tick(); #1;
    chk("bne_dec_immsrc", b0.ImmSrc, 2);
    tick(); #1;
    chk("bne_pcwrite", b0.PCWrite, 1);
    chk("bne_aluctl", b0.ALUControl, 1);
    setop(7'b1100011, 3'b111, 1'b0);
    b0.Carry = 1'b0;
    tick(); tick(); tick(); #1;
    chk("bgeu_pcwrite", b0.PCWrite, 0);
    chk("bgeu_fault", b0.Fault, 0);
    setop(7'b1100011, 3'b100, 1'b0);
    b0.Neg = 1'b1; b0.Ovf = 1'b0;
    tick(); tick(); tick(); #1;
    chk("blt_pcwrite", b0.PCWrite, 1);
    b0.Neg = 1'b0;

    // R-type sub then add
    setop(7'b0110011, 3'b000, 1'b1);
    tick(); tick(); tick(); #1;
    chk("sub_aluctl", b0.ALUControl, 1);
    chk("sub_srcb", b0.ALUSrcB, 0);
    tick(); #1;
    chk("sub_wb_regwrite", b0.RegWrite, 1);
    chk("sub_wb_resultsrc", b0.ResultSrc, 0);
    setop(7'b0110011, 3'b000, 1'b0);
    tick(); tick(); tick(); #1;
    chk("add_aluctl", b0.ALUControl, 0);

    // I-type slti
    setop(7'b0010011, 3'b010, 1'b0);
    tick(); tick(); tick(); tick(); #1;
    chk("slti_aluctl", b0.ALUControl, 5);

    // JAL
    setop(7'b1101111, 3'b000, 1'b0);
    tick(); tick(); tick(); #1;
    chk("jal_dec_immsrc", b0.ImmSrc, 3);
    tick(); #1;
    chk("jal_pcwrite", b0.PCWrite, 1);
    chk("jal_srcb", b0.ALUSrcB, 2);
    tick(); #1;
    chk("jal_wb_regwrite", b0.RegWrite, 1);

    // LUI
    setop(7'b0110111, 3'b000, 1'b0);
    tick(); tick(); tick(); #1;
    chk("lui_srca", b0.ALUSrcA, 3);
    chk("lui_immsrc", b0.ImmSrc, 4);
    tick(); tick(); #1;

    // sw with memory never ready -> FAULT after 16 cycles in MEMWRITE
    setop(7'b0100011, 3'b010, 1'b0);
    tick(); tick(); #1;
    chk("sw_adr_immsrc", b0.ImmSrc, 1);
    b0.MemReady = 1'b0;
    tick(); #1;
    chk("sw_memwrite", b0.MemWrite, 1);
    repeat (15) tick();
    #1;
    chk("to_c16_memwrite", b0.MemWrite, 1);
    chk("to_c16_fault", b0.Fault, 0);
    tick(); #1;
    chk("to_fault", b0.Fault, 1);
    chk("to_fault_memreq", b0.MemReq, 0);
    b0.MemReady = 1'b1;
    tick(); tick(); #1;
    chk("to_fault_sticky", b0.Fault, 1);
    chk("to_fault_pcwrite", b0.PCWrite, 0);

    do_reset();
    #1;
    chk("rst2_fault", b0.Fault, 0);
    chk("rst2_memreq", b0.MemReq, 1);

    // ready arrives on the limit cycle -> back to FETCH, no fault
    tick(); tick(); b0.MemReady = 1'b0;
    tick(); repeat (15) tick();
    b0.MemReady = 1'b1; #1;
    chk("lim_memwrite", b0.MemWrite, 1);
    tick(); #1;
    chk("lim_fault", b0.Fault, 0);
    chk("lim_fetch_adrsrc", b0.AdrSrc, 0);
    chk("lim_fetch_srcb", b0.ALUSrcB, 2);

    // unknown opcode
    setop(7'b1111111, 3'b000, 1'b0);
    tick(); tick(); #1;
    chk("badop_fault", b0.Fault, 1);
    do_reset();
    #1;
    chk("rst3_fault", b0.Fault, 0);
    chk("rst3_memreq", b0.MemReq, 1);
`ifdef MC_PERF_CNT_EN
    chk("rst3_instrret", b0.InstrRet, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
